// File: rtl/rs_cmd_gen.sv
// rs_cmd_gen: turns asynchronous set/clear button levels into verified r/s
// pulses for a downstream negedge-sampled RS flip-flop.
//
// Ports:
//   clk      - single clock, all state updates on the rising edge
//   rst_n    - asynchronous active-low reset
//   set_req  - asynchronous set request level
//   clr_req  - asynchronous clear request level
//   q_fb     - q of the downstream RS flip-flop
//   r, s     - registered reset/set drive, never high together
//   busy     - high whenever a command is in progress
//   done     - one-cycle pulse when a command's result is verified
//   err      - sticky flag, set on any q_fb mismatch
//   err_cnt  - saturating count of q_fb mismatches
module rs_cmd_gen #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned PULSE_W    = 2,
  parameter int unsigned GAP_W      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_req,
  input  logic       clr_req,
  input  logic       q_fb,
  output logic       r,
  output logic       s,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] err_cnt
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ECNT_W  = 4;
  localparam int unsigned CH_SET  = 0;
  localparam int unsigned CH_CLR  = 1;

  localparam logic [CNT_W-1:0]  DEB_MAX   = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0]  PULSE_END = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0]  GAP_END   = CNT_W'(GAP_W - 1);
  localparam logic [ECNT_W-1:0] ECNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_CHECK = 2'd3
  } state_e;

  // Request channels: bit 0 = set, bit 1 = clear
  logic [1:0]            req_meta_q, req_meta_d;
  logic [1:0]            req_sync_q, req_sync_d;
  logic [1:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]            deb_q, deb_d;
  logic [1:0]            deb_prev_q, deb_prev_d;
  logic                  set_pend_q, set_pend_d;
  logic                  clr_pend_q, clr_pend_d;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      tmr_q, tmr_d;
  logic                  cmd_set_q, cmd_set_d;
  logic                  r_q, r_d;
  logic                  s_q, s_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [ECNT_W-1:0]     err_cnt_q, err_cnt_d;

  logic [1:0]            rise_c;
  logic                  take_set_c, take_clr_c;

  // Synchronizers and debouncers: level rises after DEB_CYCLES highs, drops on first low
  always_comb begin
    req_meta_d = {clr_req, set_req};
    req_sync_d = req_meta_q;
    deb_cnt_d  = deb_cnt_q;
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      if (!req_sync_q[i]) begin
        deb_cnt_d[i] = '0;
        deb_d[i]     = 1'b0;
      end else if (deb_cnt_q[i] == DEB_MAX) begin
        deb_d[i]     = 1'b1;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
        deb_d[i]     = (deb_cnt_q[i] + CNT_W'(1)) == DEB_MAX;
      end
    end
    rise_c = deb_q & ~deb_prev_q;
  end

  // Command sequencer: IDLE -> PULSE -> GAP -> CHECK -> IDLE
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    cmd_set_d  = cmd_set_q;
    r_d        = 1'b0;
    s_d        = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    take_set_c = 1'b0;
    take_clr_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Clear takes priority over set
        if (clr_pend_q) begin
          state_d    = ST_PULSE;
          tmr_d      = '0;
          cmd_set_d  = 1'b0;
          r_d        = 1'b1;
          take_clr_c = 1'b1;
        end else if (set_pend_q) begin
          state_d    = ST_PULSE;
          tmr_d      = '0;
          cmd_set_d  = 1'b1;
          s_d        = 1'b1;
          take_set_c = 1'b1;
        end
      end
      ST_PULSE: begin
        if (tmr_q == PULSE_END) begin
          state_d = ST_GAP;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
          r_d   = ~cmd_set_q;
          s_d   = cmd_set_q;
        end
      end
      ST_GAP: begin
        if (tmr_q == GAP_END) begin
          // q_fb is judged on entry to CHECK so done/err are visible during CHECK
          state_d = ST_CHECK;
          tmr_d   = '0;
          if (q_fb == cmd_set_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != ECNT_MAX) begin
              err_cnt_d = err_cnt_q + ECNT_W'(1);
            end
          end
        end else begin
          tmr_d = tmr_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);

    // One-deep pending flags; simultaneous edges keep only the clear
    clr_pend_d = (clr_pend_q & ~take_clr_c) | rise_c[CH_CLR];
    set_pend_d = (set_pend_q & ~take_set_c) | (rise_c[CH_SET] & ~rise_c[CH_CLR]);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta_q <= '0;
      req_sync_q <= '0;
      deb_cnt_q  <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      set_pend_q <= 1'b0;
      clr_pend_q <= 1'b0;
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      cmd_set_q  <= 1'b0;
      r_q        <= 1'b0;
      s_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      req_meta_q <= req_meta_d;
      req_sync_q <= req_sync_d;
      deb_cnt_q  <= deb_cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      set_pend_q <= set_pend_d;
      clr_pend_q <= clr_pend_d;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      cmd_set_q  <= cmd_set_d;
      r_q        <= r_d;
      s_q        <= s_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign r       = r_q;
  assign s       = s_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_rs_cmd_gen.sv
// tb_rs_cmd_gen: directed and randomized checks of rs_cmd_gen against a
// cycle-indexed behavioural model of request timing and command execution.
module tb_rs_cmd_gen;

  localparam int D    = 4;
  localparam int P    = 2;
  localparam int G    = 2;
  localparam int MAXE = 65536;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       set_req = 1'b0;
  logic       clr_req = 1'b0;
  logic       q_fb;
  logic       r, s, busy, done, err;
  logic [3:0] err_cnt;

  logic       rs_q    = 1'b0;
  logic       q_tie0  = 1'b0;

  int errors = 0;
  int checks = 0;

  rs_cmd_gen #(.DEB_CYCLES(D), .PULSE_W(P), .GAP_W(G)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_req (set_req),
    .clr_req (clr_req),
    .q_fb    (q_fb),
    .r       (r),
    .s       (s),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  // Downstream RS flip-flop, sampling r/s on the falling edge
  always @(negedge clk) begin
    if (s)      rs_q <= 1'b1;
    else if (r) rs_q <= 1'b0;
  end
  assign q_fb = q_tie0 ? 1'b0 : rs_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit hs [0:MAXE-1];
  bit hc [0:MAXE-1];
  int e  = 0;   // index of the next rising edge
  int n0 = 0;   // first edge index after the latest reset
  bit m_act = 0, m_kind = 0, m_ps = 0, m_pc = 0, m_done = 0, m_err = 0;
  int m_t = 0, m_cnt = 0;

  function automatic bit req_at(input bit ch, input int k);
    if (k < n0) return 1'b0;
    return ch ? hc[k] : hs[k];
  endfunction

  // Debounced level after edge m: the D request samples taken at edges m-1-D .. m-2 all high
  function automatic bit deb(input bit ch, input int m);
    for (int j = m - 1 - D; j <= m - 2; j++) begin
      if (!req_at(ch, j)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_outs();
    bit er, es;
    es = m_act && m_kind && (m_t < P);
    er = m_act && !m_kind && (m_t < P);
    return 32'({er, es, m_act, m_done, m_err, 4'(m_cnt)});
  endfunction

  initial begin
    bit rs_e, rc_e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n0 = e;
        m_act = 0; m_kind = 0; m_ps = 0; m_pc = 0; m_done = 0; m_err = 0;
        m_t = 0; m_cnt = 0;
      end else begin
        hs[e] = set_req;
        hc[e] = clr_req;
        rs_e = deb(1'b0, e - 1) && !deb(1'b0, e - 2);
        rc_e = deb(1'b1, e - 1) && !deb(1'b1, e - 2);
        if (rc_e) rs_e = 1'b0;
        m_done = 0;
        if (m_act) begin
          m_t++;
          if (m_t == P + G) begin
            if (q_fb == m_kind) m_done = 1;
            else begin
              m_err = 1;
              if (m_cnt < 15) m_cnt++;
            end
          end else if (m_t > P + G) begin
            m_act = 0;
          end
        end else if (m_pc) begin
          m_act = 1; m_kind = 0; m_t = 0; m_pc = 0;
        end else if (m_ps) begin
          m_act = 1; m_kind = 1; m_t = 0; m_ps = 0;
        end
        m_pc = m_pc | rc_e;
        m_ps = m_ps | rs_e;
        e++;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) chk("cycle", 32'({r, s, busy, done, err, err_cnt}), exp_outs());
    end
  end

  function automatic logic [31:0] outs_now();
    return 32'({r, s, busy, done, err, err_cnt});
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_outs", outs_now(), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s_first, s_last, s_cnt, r_first, r_cnt, busy_cnt, done_edge, done_cnt, k;
    bit seen;

    repeat (2) @(negedge clk);
    do_reset();
    repeat (3) @(negedge clk);

    // Single set command, request held 10 edges
    s_first = 0; s_last = 0; s_cnt = 0; r_cnt = 0; busy_cnt = 0; done_edge = 0; done_cnt = 0;
    @(negedge clk); set_req = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      if (s) begin if (s_first == 0) s_first = i; s_last = i; s_cnt++; end
      if (r) r_cnt++;
      if (busy) busy_cnt++;
      if (done) begin done_edge = i; done_cnt++; end
      if (i == 10) set_req = 1'b0;
    end
    chk("set_s_first", 32'(s_first), 32'(D + 4));
    chk("set_s_last", 32'(s_last), 32'(D + 3 + P));
    chk("set_s_cnt", 32'(s_cnt), 32'(P));
    chk("set_r_cnt", 32'(r_cnt), 32'd0);
    chk("set_busy_cnt", 32'(busy_cnt), 32'(P + G + 1));
    chk("set_done_edge", 32'(done_edge), 32'(D + 4 + P + G));
    chk("set_done_cnt", 32'(done_cnt), 32'd1);
    chk("set_err", 32'(err), 32'd0);
    chk("set_q", 32'(q_fb), 32'd1);

    // Short glitch below the debounce length
    @(negedge clk); set_req = 1'b1;
    repeat (D - 1) @(negedge clk);
    set_req = 1'b0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (r || s || busy || done) k++;
    end
    chk("glitch_activity", 32'(k), 32'd0);

    // Simultaneous set and clear edges: clear wins
    s_cnt = 0; r_cnt = 0;
    @(negedge clk); set_req = 1'b1; clr_req = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (s) s_cnt++;
      if (r) r_cnt++;
      if (i == 10) begin set_req = 1'b0; clr_req = 1'b0; end
    end
    chk("both_r_cnt", 32'(r_cnt), 32'(P));
    chk("both_s_cnt", 32'(s_cnt), 32'd0);
    chk("both_q", 32'(q_fb), 32'd0);

    // Clear arriving during a set command is queued and served next
    r_first = 0; done_edge = 0; s_cnt = 0;
    @(negedge clk); set_req = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (r && r_first == 0) r_first = i;
      if (s) s_cnt++;
      if (done && done_edge == 0) done_edge = i;
      if (i == 2) clr_req = 1'b1;
      if (i == 10) set_req = 1'b0;
      if (i == 12) clr_req = 1'b0;
    end
    chk("queue_set_done", 32'(done_edge), 32'(D + 4 + P + G));
    chk("queue_s_cnt", 32'(s_cnt), 32'(P));
    chk("queue_r_first", 32'(r_first), 32'(D + 4 + P + G + 2));

    // Feedback stuck low: errors accumulate and saturate
    do_reset();
    q_tie0 = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk); set_req = 1'b1;
      repeat (D + 2) @(negedge clk);
      set_req = 1'b0;
      for (int i = 0; i < P + G + 10; i++) begin
        @(posedge clk); #1;
        if (done) done_cnt++;
      end
      if (c == 0) begin
        chk("stuck_err", 32'(err), 32'd1);
        chk("stuck_err_cnt1", 32'(err_cnt), 32'd1);
      end
    end
    chk("stuck_done_cnt", 32'(done_cnt), 32'd0);
    chk("stuck_err_cnt_sat", 32'(err_cnt), 32'd15);
    q_tie0 = 1'b0;

    // Reset mid-pulse, request still held: aborted, then re-requested
    do_reset();
    @(negedge clk); set_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (s) seen = 1'b1;
    end
    chk("abort_s_seen", 32'(seen), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("abort_rst_outs", outs_now(), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    s_first = 0;
    for (int i = 1; i <= 40 && s_first == 0; i++) begin
      @(posedge clk); #1;
      if (s) s_first = i;
    end
    chk("rearm_s_first", 32'(s_first), 32'(D + 4));
    repeat (P + G + 4) @(negedge clk);
    set_req = 1'b0;

    // Randomized requests, feedback faults and resets
    for (int it = 0; it < 800; it++) begin
      @(negedge clk);
      set_req = 1'($urandom_range(0, 1));
      clr_req = ($urandom_range(0, 3) == 0);
      q_tie0  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rand_rst_outs", outs_now(), 32'd0);
        @(negedge clk); rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 12)) begin
        @(negedge clk);
        if (r && s) chk("rand_r_and_s", 32'd1, 32'd0);
      end
    end

    set_req = 1'b0; clr_req = 1'b0; q_tie0 = 1'b0;
    repeat (30) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
